// File: rtl/vtc_param_if.sv
// Video timing output bundle: raw counters, sync levels, active-region
// coordinates and the per-line / per-frame pulses of one timing generator.
interface vtc_param_if #(
    parameter int unsigned CNT_W = 12
) ();
    logic             hSync;
    logic             vSync;
    logic [CNT_W-1:0] hPixel;
    logic [CNT_W-1:0] line;
    logic             video_active;
    logic [CNT_W-1:0] active_x;
    logic [CNT_W-1:0] active_y;
    logic             line_start;
    logic             frame_start;

    // Timing generator side drives everything.
    modport master (
        output hSync, vSync, hPixel, line, video_active,
        output active_x, active_y, line_start, frame_start
    );

    // Consumers (pixel pipeline, display PHY) only observe.
    modport slave (
        input hSync, vSync, hPixel, line, video_active,
        input active_x, active_y, line_start, frame_start
    );
endinterface

// File: rtl/vtc_param.sv
// Parameterised video timing controller.
// Line layout is sync, back porch, active, front porch (same order for frames).
// All outputs are registered and decoded from the counter values they are
// presented with, so there is no skew between counters and decoded signals.
// Optional macro VTC_RUNTIME_TIMING_EN adds a cfg_valid/cfg_ready/cfg_timing
// handshake that loads a shadow timing set, made live at the next (0,0) wrap.
module vtc_param #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 12
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               ce,
`ifdef VTC_RUNTIME_TIMING_EN
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [8*CNT_W-1:0] cfg_timing,
`endif
    vtc_param_if.master        vid
);

    // Two spare bits so porch/sync sums never overflow.
    localparam int unsigned SW = CNT_W + 2;

    // Field order matches cfg_timing packing, H_ACTIVE in the MSBs.
    typedef struct packed {
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_act;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
    } timing_t;

    localparam timing_t ParamTiming = '{
        h_act:  CNT_W'(H_ACTIVE),
        h_fp:   CNT_W'(H_FP),
        h_sync: CNT_W'(H_SYNC),
        h_bp:   CNT_W'(H_BP),
        v_act:  CNT_W'(V_ACTIVE),
        v_fp:   CNT_W'(V_FP),
        v_sync: CNT_W'(V_SYNC),
        v_bp:   CNT_W'(V_BP)
    };

    // live: timing governing the current frame (wrap points).
    // nxt:  timing governing the position being loaded this edge (decode).
    timing_t live;
    timing_t nxt;

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             va_q, va_d;
    logic [CNT_W-1:0] ax_q, ax_d;
    logic [CNT_W-1:0] ay_q, ay_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             frame_wrap;

    logic [SW-1:0] h_last_val, v_last_val;
    logic          h_last, v_last;
    logic [SW-1:0] h_beg, h_end, v_beg, v_end;
    logic          h_in, v_in;
    logic          nxt_fp_unused;

`ifdef VTC_RUNTIME_TIMING_EN
    timing_t live_q;
    timing_t shadow_q;
    logic    pending_q;
    logic    cfg_ready_q;
    logic    capture;
    logic    apply;

    assign capture   = cfg_valid & cfg_ready_q;
    // pending_q is the pre-edge value, so a capture on the wrap edge itself
    // waits for the following frame.
    assign apply     = frame_wrap & pending_q;
    assign live      = live_q;
    assign nxt       = apply ? shadow_q : live_q;
    assign cfg_ready = cfg_ready_q;

    // Shadow capture and frame-aligned hand-over of runtime timing.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            live_q      <= ParamTiming;
            shadow_q    <= ParamTiming;
            pending_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            if (apply) begin
                live_q    <= shadow_q;
                pending_q <= 1'b0;
            end
            if (capture) begin
                shadow_q  <= timing_t'(cfg_timing);
                pending_q <= 1'b1;
            end
            // Ready drops on capture and returns one cycle after the hand-over.
            cfg_ready_q <= capture ? 1'b0 : ~pending_q;
        end
    end
`else
    assign live = ParamTiming;
    assign nxt  = ParamTiming;
`endif

    assign h_last_val = SW'(live.h_sync) + SW'(live.h_bp) + SW'(live.h_act)
                      + SW'(live.h_fp) - SW'(1);
    assign v_last_val = SW'(live.v_sync) + SW'(live.v_bp) + SW'(live.v_act)
                      + SW'(live.v_fp) - SW'(1);
    assign h_last     = (SW'(h_q) == h_last_val);
    assign v_last     = (SW'(v_q) == v_last_val);

    assign h_beg = SW'(nxt.h_sync) + SW'(nxt.h_bp);
    assign h_end = h_beg + SW'(nxt.h_act);
    assign v_beg = SW'(nxt.v_sync) + SW'(nxt.v_bp);
    assign v_end = v_beg + SW'(nxt.v_act);
    assign h_in  = (SW'(h_d) >= h_beg) && (SW'(h_d) < h_end);
    assign v_in  = (SW'(v_d) >= v_beg) && (SW'(v_d) < v_end);

    // Front porches only matter for the wrap points, which use live timing.
    assign nxt_fp_unused = ^{nxt.h_fp, nxt.v_fp};

    // Next counter position; line only advances on the hPixel wrap.
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        frame_wrap = 1'b0;
        if (ce) begin
            if (h_last) begin
                h_d = '0;
                if (v_last) begin
                    v_d        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Decode from the next position so outputs line up with the counters.
    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        va_d = va_q;
        ax_d = ax_q;
        ay_d = ay_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (ce) begin
            hs_d = (SW'(h_d) < SW'(nxt.h_sync)) ? HSYNC_POL : ~HSYNC_POL;
            vs_d = (SW'(v_d) < SW'(nxt.v_sync)) ? VSYNC_POL : ~VSYNC_POL;
            va_d = h_in & v_in;
            ax_d = (h_in & v_in) ? CNT_W'(SW'(h_d) - h_beg) : '0;
            ay_d = (h_in & v_in) ? CNT_W'(SW'(v_d) - v_beg) : '0;
            ls_d = (h_d == '0);
            fs_d = (h_d == '0) && (v_d == '0);
        end
    end

    // Counter and output registers; reset parks syncs at their idle level.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= ~HSYNC_POL;
            vs_q <= ~VSYNC_POL;
            va_q <= 1'b0;
            ax_q <= '0;
            ay_q <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            va_q <= va_d;
            ax_q <= ax_d;
            ay_q <= ay_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign vid.hPixel       = h_q;
    assign vid.line         = v_q;
    assign vid.hSync        = hs_q;
    assign vid.vSync        = vs_q;
    assign vid.video_active = va_q;
    assign vid.active_x     = ax_q;
    assign vid.active_y     = ay_q;
    assign vid.line_start   = ls_q;
    assign vid.frame_start  = fs_q;

endmodule

// File: tb/tb_vtc_param.sv
// Directed bench for vtc_param: default 800x525 timing (first active region),
// a 7x7 active-high-hSync instance, and a 15x8 instance for frame wrap,
// ce hold, mid-frame reset and (with VTC_RUNTIME_TIMING_EN) runtime timing.
module tb_vtc_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ce = 1'b0;
    logic cfg_valid = 1'b0;
    logic [95:0] cfg_timing = '0;
    logic cfg_ready2;

    int nvec = 0;
    int nerr = 0;
    logic [52:0] got, want;

    always #5 clk = ~clk;

    vtc_param_if #(.CNT_W(12)) if0 ();
    vtc_param_if #(.CNT_W(12)) if1 ();
    vtc_param_if #(.CNT_W(12)) if2 ();

`ifdef VTC_RUNTIME_TIMING_EN
    logic cfg_ready0_unused, cfg_ready1_unused;
`endif

    vtc_param u_d0 (
        .clock_in   (clk),
        .reset      (rst_n),
        .ce         (ce),
`ifdef VTC_RUNTIME_TIMING_EN
        .cfg_valid  (1'b0),
        .cfg_ready  (cfg_ready0_unused),
        .cfg_timing (96'd0),
`endif
        .vid        (if0)
    );

    vtc_param #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1)
    ) u_d1 (
        .clock_in   (clk),
        .reset      (rst_n),
        .ce         (ce),
`ifdef VTC_RUNTIME_TIMING_EN
        .cfg_valid  (1'b0),
        .cfg_ready  (cfg_ready1_unused),
        .cfg_timing (96'd0),
`endif
        .vid        (if1)
    );

    vtc_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_d2 (
        .clock_in   (clk),
        .reset      (rst_n),
        .ce         (ce),
`ifdef VTC_RUNTIME_TIMING_EN
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready2),
        .cfg_timing (cfg_timing),
`endif
        .vid        (if2)
    );

`ifndef VTC_RUNTIME_TIMING_EN
    assign cfg_ready2 = 1'b0;
`endif

    // Expected-state constructor: {hPixel, line, hSync, vSync, active, x, y, ls, fs}.
    function automatic logic [52:0] pk(input int h, input int l, input int hs, input int vs,
                                       input int va, input int ax, input int ay,
                                       input int ls, input int fs);
        return {h[11:0], l[11:0], hs[0], vs[0], va[0], ax[11:0], ay[11:0], ls[0], fs[0]};
    endfunction

    function automatic logic [52:0] s0();
        return {if0.hPixel, if0.line, if0.hSync, if0.vSync, if0.video_active,
                if0.active_x, if0.active_y, if0.line_start, if0.frame_start};
    endfunction

    function automatic logic [52:0] s1();
        return {if1.hPixel, if1.line, if1.hSync, if1.vSync, if1.video_active,
                if1.active_x, if1.active_y, if1.line_start, if1.frame_start};
    endfunction

    function automatic logic [52:0] s2();
        return {if2.hPixel, if2.line, if2.hSync, if2.vSync, if2.video_active,
                if2.active_x, if2.active_y, if2.line_start, if2.frame_start};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        ce = 1'b0;
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        got = s0(); want = pk(0, 0, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL reset_d0: got %h want %h", got, want); end
        got = s1(); want = pk(0, 0, 0, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL reset_d1: got %h want %h", got, want); end
        got = s2(); want = pk(0, 0, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL reset_d2: got %h want %h", got, want); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_default_timing();
        ce = 1'b1;
        step(1);
        got = s0(); want = pk(1, 0, 0, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_first_edge: got %h want %h", got, want); end
        step(94);
        got = s0(); want = pk(95, 0, 0, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_hsync_last: got %h want %h", got, want); end
        step(1);
        got = s0(); want = pk(96, 0, 1, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_hsync_off: got %h want %h", got, want); end
        step(703);
        got = s0(); want = pk(799, 0, 1, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_line_end: got %h want %h", got, want); end
        step(1);
        got = s0(); want = pk(0, 1, 0, 0, 0, 0, 0, 1, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_line1: got %h want %h", got, want); end
        step(800);
        got = s0(); want = pk(0, 2, 0, 1, 0, 0, 0, 1, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_line2: got %h want %h", got, want); end
        step(26543);
        got = s0(); want = pk(143, 35, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_pre_active: got %h want %h", got, want); end
        step(1);
        got = s0(); want = pk(144, 35, 1, 1, 1, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_first_active: got %h want %h", got, want); end
        step(639);
        got = s0(); want = pk(783, 35, 1, 1, 1, 639, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_row_end: got %h want %h", got, want); end
        step(1);
        got = s0(); want = pk(784, 35, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL dflt_post_active: got %h want %h", got, want); end
    endtask

    // 7x7 timing, hSync active-high: high only at hPixel 0, active at 2..5.
    task automatic test_small_timing();
        int h, v, va;
        do_reset();
        ce = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            step(1);
            h = k % 7;
            v = k / 7;
            va = (h >= 2 && h <= 5 && v >= 2) ? 1 : 0;
            got = s1();
            want = pk(h, v, (h == 0) ? 1 : 0, (v < 1) ? 0 : 1, va,
                      va ? h - 2 : 0, va ? v - 2 : 0, (h == 0) ? 1 : 0, 0);
            nvec++;
            if (got !== want) begin
                nerr++;
                $display("FAIL small_k%0d: got %h want %h", k, got, want);
            end
        end
        step(28);
        got = s1(); want = pk(0, 0, 1, 0, 0, 0, 0, 1, 1); nvec++;
        if (got !== want) begin nerr++; $display("FAIL small_frame_wrap: got %h want %h", got, want); end
    endtask

    task automatic test_ce_hold();
        do_reset();
        ce = 1'b1;
        step(119);
        got = s2(); want = pk(14, 7, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL hold_last_pos: got %h want %h", got, want); end
        ce = 1'b0;
        step(1);
        got = s2(); nvec++;
        if (got !== want) begin nerr++; $display("FAIL hold_cycle1: got %h want %h", got, want); end
        step(1);
        got = s2(); nvec++;
        if (got !== want) begin nerr++; $display("FAIL hold_cycle2: got %h want %h", got, want); end
        ce = 1'b1;
        step(1);
        got = s2(); want = pk(0, 0, 0, 0, 0, 0, 0, 1, 1); nvec++;
        if (got !== want) begin nerr++; $display("FAIL hold_wrap: got %h want %h", got, want); end
        ce = 1'b0;
        step(1);
        got = s2(); want = pk(0, 0, 0, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL hold_pulse_kill: got %h want %h", got, want); end
        ce = 1'b1;
        step(1);
        got = s2(); want = pk(1, 0, 0, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL hold_resume: got %h want %h", got, want); end
    endtask

    // 15x8 instance: active hPixel 5..12, lines 3..6.
    task automatic test_active_bounds();
        do_reset();
        ce = 1'b1;
        step(49);
        got = s2(); want = pk(4, 3, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL bounds_pre: got %h want %h", got, want); end
        step(1);
        got = s2(); want = pk(5, 3, 1, 1, 1, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL bounds_first: got %h want %h", got, want); end
        step(52);
        got = s2(); want = pk(12, 6, 1, 1, 1, 7, 3, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL bounds_last: got %h want %h", got, want); end
        step(1);
        got = s2(); want = pk(13, 6, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL bounds_post: got %h want %h", got, want); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        ce = 1'b1;
        step(55);
        got = s2(); want = pk(10, 3, 1, 1, 1, 5, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL midrst_before: got %h want %h", got, want); end
        rst_n = 1'b0;
        #2;
        got = s2(); want = pk(0, 0, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL midrst_async: got %h want %h", got, want); end
        step(1);
        got = s2(); nvec++;
        if (got !== want) begin nerr++; $display("FAIL midrst_held: got %h want %h", got, want); end
        rst_n = 1'b1;
        step(1);
        got = s2(); want = pk(1, 0, 0, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL midrst_restart: got %h want %h", got, want); end
    endtask

`ifdef VTC_RUNTIME_TIMING_EN
    task automatic test_runtime_cfg();
        do_reset();
        nvec++;
        if (cfg_ready2 !== 1'b1) begin nerr++; $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready2); end
        ce = 1'b1;
        step(20);
        cfg_valid = 1'b1;
        cfg_timing = {12'd4, 12'd1, 12'd1, 12'd1, 12'd4, 12'd1, 12'd1, 12'd1};
        step(1);
        cfg_valid = 1'b0;
        nvec++;
        if (cfg_ready2 !== 1'b0) begin nerr++; $display("FAIL cfg_ready_drop: got %b want 0", cfg_ready2); end
        got = s2(); want = pk(6, 1, 1, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_capture_pos: got %h want %h", got, want); end
        step(98);
        got = s2(); want = pk(14, 7, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_old_end: got %h want %h", got, want); end
        step(1);
        got = s2(); want = pk(0, 0, 0, 0, 0, 0, 0, 1, 1); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_wrap: got %h want %h", got, want); end
        nvec++;
        if (cfg_ready2 !== 1'b0) begin nerr++; $display("FAIL cfg_ready_at_wrap: got %b want 0", cfg_ready2); end
        step(1);
        got = s2(); want = pk(1, 0, 1, 0, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_new_h1: got %h want %h", got, want); end
        nvec++;
        if (cfg_ready2 !== 1'b1) begin nerr++; $display("FAIL cfg_ready_back: got %b want 1", cfg_ready2); end
        step(6);
        got = s2(); want = pk(0, 1, 0, 1, 0, 0, 0, 1, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_new_line: got %h want %h", got, want); end
        step(9);
        got = s2(); want = pk(2, 2, 1, 1, 1, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_new_active: got %h want %h", got, want); end
        step(32);
        got = s2(); want = pk(6, 6, 1, 1, 0, 0, 0, 0, 0); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_new_end: got %h want %h", got, want); end
        step(1);
        got = s2(); want = pk(0, 0, 0, 0, 0, 0, 0, 1, 1); nvec++;
        if (got !== want) begin nerr++; $display("FAIL cfg_new_wrap: got %h want %h", got, want); end
    endtask
`endif

    initial begin
        test_reset();
        test_default_timing();
        test_small_timing();
        test_ce_hold();
        test_active_bounds();
        test_reset_midframe();
`ifdef VTC_RUNTIME_TIMING_EN
        test_runtime_cfg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vtc_param.md
VTC_PARAM -- requirements
Module: vtc_param

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, default 96: hSync pulse width, in clocks.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in clocks.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical equivalents, in lines.
REQ-006 Parameters HSYNC_POL/VSYNC_POL, default 0/0: asserted sync level (0 = active-low).
REQ-007 Parameter CNT_W, default 12: counter and coordinate width.
REQ-008 clock_in  in  1  pixel clock; single clock domain.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 ce  in  1  count enable; all state holds when low.
REQ-011 hSync, vSync  out  1 each  sync outputs at configured polarity.
REQ-012 hPixel, line  out  CNT_W each  raw horizontal/vertical counters.
REQ-013 video_active  out  1  high inside the active region.
REQ-014 active_x, active_y  out  CNT_W each  active-region coordinates; 0 when video_active is low.
REQ-015 line_start, frame_start  out  1 each  single-cycle pulses.

Function
REQ-016 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL is formed the same way from the V_* values; each field ≥1; H_TOTAL-1 and V_TOTAL-1 shall fit in CNT_W bits.
REQ-017 On each edge with ce=1, hPixel shall increment, and shall wrap from H_TOTAL-1 to 0.
REQ-018 On the hPixel wrap, line shall increment, and shall wrap from V_TOTAL-1 to 0; line shall change only on the hPixel wrap.
REQ-019 With ce=0, hPixel, line and all decoded outputs shall hold their values; pulses shall be forced to 0.
REQ-020 All outputs shall be registered; decoded outputs shall correspond to the hPixel/line values presented in the same cycle (zero relative latency).
REQ-021 hSync shall be asserted when hPixel < H_SYNC; vSync shall be asserted when line < V_SYNC.
REQ-022 video_active shall be high when both hold: H_SYNC+H_BP ≤ hPixel < H_SYNC+H_BP+H_ACTIVE, and V_SYNC+V_BP ≤ line < V_SYNC+V_BP+V_ACTIVE.
REQ-023 When video_active is high, active_x = hPixel-(H_SYNC+H_BP) and active_y = line-(V_SYNC+V_BP).
REQ-024 line_start shall be high for one cycle when hPixel=0 with ce=1; frame_start shall be high for one cycle when hPixel=0, line=0 with ce=1.

Reset
REQ-025 When reset is low, the block shall force hPixel=0, line=0, hSync=!HSYNC_POL, vSync=!VSYNC_POL, video_active=0, active_x=active_y=0 and pulses=0, asynchronously.
REQ-026 The first ce=1 edge after reset release shall produce hPixel=1, line=0, with outputs decoded per REQ-021..024; there is no frame_start for this partial first frame.
REQ-027 Reset asserted mid-frame shall abort the frame immediately, and any pending configuration update shall be discarded.

Configuration
REQ-028 Macro VTC_RUNTIME_TIMING_EN shall add ports cfg_valid (in, 1), cfg_ready (out, 1) and cfg_timing (in, 8*CNT_W), packed {H_ACTIVE,H_FP,H_SYNC,H_BP,V_ACTIVE,V_FP,V_SYNC,V_BP} with H_ACTIVE in the MSBs.
REQ-029 With the macro defined, cfg_ready shall be 1 when no update is pending.
REQ-030 With the macro defined, cfg_valid&cfg_ready shall capture cfg_timing into a shadow register, and cfg_ready shall then drop.
REQ-031 With the macro defined, the shadow register shall become live on the edge where the counters wrap to (0,0); cfg_ready shall rise on the following cycle.
REQ-032 With the macro defined, an update captured while counters are at (H_TOTAL-1, V_TOTAL-1) shall apply at the next wrap, not the current one; reset shall reload the parameter values.
REQ-033 Without the macro, those ports shall be absent and timing shall be fixed by parameters.

Verification
REQ-034 Defaults, ce=1, 2 frames: 800 clocks per line, 525 lines per frame; hSync low for hPixel 0..95; vSync low for line 0..1.
REQ-035 Defaults: video_active first high at hPixel=144, line=35 with active_x=0, active_y=0; last high at hPixel=783, line=514 with active_x=639, active_y=479.
REQ-036 HSYNC_POL=1, H_ACTIVE=4, H_FP=H_SYNC=H_BP=1: period 7 clocks; hSync high only at hPixel=0; active at hPixel 2..5.
REQ-037 ce toggled 1,0,0,1 at hPixel=799, line=524: counters hold for 2 cycles, then wrap to 0/0 with a single frame_start pulse.
REQ-038 Reset pulsed low at hPixel=300, line=200: outputs take reset values immediately; after release the count restarts at hPixel=1, line=0.
REQ-039 VTC_RUNTIME_TIMING_EN, cfg for 4/1/1/1 per axis accepted mid-frame: the old timing completes; the next frame uses a 7x7 total; cfg_ready returns to 1 one cycle after the wrap.
